// File: rtl/cva6_clic_irq_arbiter.sv
// CLIC interrupt arbiter: edge/level pending capture, two-stage registered max-level
// selection against a threshold, and a valid/ack handshake with post-ack blanking.
`timescale 1ns/1ps
module cva6_clic_irq_arbiter #(
  parameter int unsigned NumSrc     = 256,
  parameter int unsigned LevelWidth = 8,
  parameter int unsigned GroupSize  = 16,
  parameter int unsigned IdWidth    = $clog2(NumSrc)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumSrc-1:0]            src_i,
  input  logic [NumSrc-1:0]            ie_i,
  input  logic [NumSrc-1:0]            edge_i,
  input  logic [NumSrc*LevelWidth-1:0] level_i,
  input  logic [LevelWidth-1:0]        thresh_i,
  output logic                         irq_valid_o,
  output logic [IdWidth-1:0]           irq_id_o,
  output logic [LevelWidth-1:0]        irq_level_o,
  input  logic                         irq_ack_i,
  output logic [NumSrc-1:0]            pending_o
);

  localparam int unsigned NumGrp = NumSrc / GroupSize;

  logic [NumSrc-1:0]                 src_q;
  logic [NumSrc-1:0]                 ip_d, ip_q;
  logic [NumSrc-1:0]                 rise, clr_vec, pending, cand;
  logic [NumSrc-1:0][LevelWidth-1:0] src_lvl;
  logic                              ack_acc;

  logic [NumGrp-1:0]                 grp_v_d, grp_v_q;
  logic [NumGrp-1:0][LevelWidth-1:0] grp_lvl_d, grp_lvl_q;
  logic [NumGrp-1:0][IdWidth-1:0]    grp_id_d, grp_id_q;

  logic                              win_v;
  logic [LevelWidth-1:0]             win_lvl;
  logic [IdWidth-1:0]                win_id;

  logic                              irq_valid_d, irq_valid_q;
  logic [IdWidth-1:0]                irq_id_d, irq_id_q;
  logic [LevelWidth-1:0]             irq_level_d, irq_level_q;
  logic [1:0]                        blank_cnt_d, blank_cnt_q;

  assign src_lvl = level_i;
  assign ack_acc = irq_ack_i & irq_valid_q;
  assign rise    = src_i & ~src_q;

  always_comb begin
    clr_vec = '0;
    for (int k = 0; k < NumSrc; k++) begin
      clr_vec[k] = ack_acc && (irq_id_q == IdWidth'(k));
    end
  end

  // Set beats clear; leaving edge mode drops any latched edge.
  assign ip_d    = edge_i & (rise | (ip_q & ~clr_vec));
  assign pending = (edge_i & ip_q) | (~edge_i & src_i);
  assign cand    = pending & ie_i;

  // Stage 1: per-group winner; ascending scan with >= lets the higher id win ties.
  always_comb begin
    grp_v_d   = '0;
    grp_lvl_d = '0;
    grp_id_d  = '0;
    for (int g = 0; g < NumGrp; g++) begin
      for (int i = 0; i < GroupSize; i++) begin
        if (cand[g*GroupSize+i] &&
            (!grp_v_d[g] || src_lvl[g*GroupSize+i] >= grp_lvl_d[g])) begin
          grp_v_d[g]   = 1'b1;
          grp_lvl_d[g] = src_lvl[g*GroupSize+i];
          grp_id_d[g]  = IdWidth'(g*GroupSize+i);
        end
      end
    end
  end

  // Stage 2: reduce group winners with the same rule.
  always_comb begin
    win_v   = 1'b0;
    win_lvl = '0;
    win_id  = '0;
    for (int g = 0; g < NumGrp; g++) begin
      if (grp_v_q[g] && (!win_v || grp_lvl_q[g] >= win_lvl)) begin
        win_v   = 1'b1;
        win_lvl = grp_lvl_q[g];
        win_id  = grp_id_q[g];
      end
    end
  end

  // Blanking hides the two pipeline slots computed from pre-clear pending state.
  always_comb begin
    blank_cnt_d = blank_cnt_q;
    if (ack_acc) begin
      blank_cnt_d = 2'd2;
    end else if (blank_cnt_q != 2'd0) begin
      blank_cnt_d = blank_cnt_q - 2'd1;
    end
    irq_valid_d = win_v && (win_lvl > thresh_i) && (blank_cnt_d == 2'd0);
    irq_id_d    = win_id;
    irq_level_d = win_lvl;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q       <= '0;
      ip_q        <= '0;
      grp_v_q     <= '0;
      grp_lvl_q   <= '0;
      grp_id_q    <= '0;
      blank_cnt_q <= 2'd0;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      irq_level_q <= '0;
    end else begin
      src_q       <= src_i;
      ip_q        <= ip_d;
      grp_v_q     <= grp_v_d;
      grp_lvl_q   <= grp_lvl_d;
      grp_id_q    <= grp_id_d;
      blank_cnt_q <= blank_cnt_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      irq_level_q <= irq_level_d;
    end
  end

  assign irq_valid_o = irq_valid_q;
  assign irq_id_o    = irq_id_q;
  assign irq_level_o = irq_level_q;
  assign pending_o   = pending;

endmodule

// File: tb/tb_cva6_clic_irq_arbiter.sv
// Bench for cva6_clic_irq_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a flat whole-array max-search model with explicit latencies.
`timescale 1ns/1ps
module tb_cva6_clic_irq_arbiter;

  localparam int NumSrc     = 256;
  localparam int LevelWidth = 8;
  localparam int GroupSize  = 16;
  localparam int IdWidth    = 8;

  logic                         clk = 1'b0;
  logic                         rst_ni = 1'b0;
  logic [NumSrc-1:0]            src = '0;
  logic [NumSrc-1:0]            ie = '1;
  logic [NumSrc-1:0]            edge_mode = '0;
  logic [NumSrc*LevelWidth-1:0] level_vec = '0;
  logic [LevelWidth-1:0]        thresh = '0;
  logic                         ack = 1'b0;
  logic                         valid;
  logic [IdWidth-1:0]           id;
  logic [LevelWidth-1:0]        lvl_o;
  logic [NumSrc-1:0]            pending;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cva6_clic_irq_arbiter #(
    .NumSrc    (NumSrc),
    .LevelWidth(LevelWidth),
    .GroupSize (GroupSize)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .src_i      (src),
    .ie_i       (ie),
    .edge_i     (edge_mode),
    .level_i    (level_vec),
    .thresh_i   (thresh),
    .irq_valid_o(valid),
    .irq_id_o   (id),
    .irq_level_o(lvl_o),
    .irq_ack_i  (ack),
    .pending_o  (pending)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [NumSrc-1:0] act,
                           input logic [NumSrc-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NumSrc-1:0] ip_m, src_prev_m;
  logic              m_valid, ack_prev_m, w1_v;
  int                m_id, m_lvl, w1_id, w1_lvl;

  task automatic model_reset();
    ip_m = '0; src_prev_m = '0;
    m_valid = 1'b0; m_id = 0; m_lvl = 0;
    w1_v = 1'b0; w1_id = 0; w1_lvl = 0;
    ack_prev_m = 1'b0;
  endtask

  function automatic logic [NumSrc-1:0] model_pending();
    return (edge_mode & ip_m) | (~edge_mode & src);
  endfunction

  task automatic find_winner(input logic [NumSrc-1:0] c, output logic v, output int wid,
                             output int wlv);
    v = 1'b0; wid = 0; wlv = 0;
    for (int k = 0; k < NumSrc; k++) begin
      if (c[k] && (!v || int'(level_vec[k*LevelWidth +: LevelWidth]) >= wlv)) begin
        v = 1'b1; wid = k; wlv = int'(level_vec[k*LevelWidth +: LevelWidth]);
      end
    end
  endtask

  // Advance the model across one clock edge using the inputs of the current cycle.
  task automatic model_step();
    logic ack_acc, nv;
    int nid, nlv;
    ack_acc = ack && m_valid;
    find_winner(model_pending() & ie, nv, nid, nlv);
    for (int k = 0; k < NumSrc; k++) begin
      if (!edge_mode[k]) ip_m[k] = 1'b0;
      else if (src[k] && !src_prev_m[k]) ip_m[k] = 1'b1;
      else if (ack_acc && m_id == k) ip_m[k] = 1'b0;
    end
    m_valid = w1_v && (w1_lvl > int'(thresh)) && !ack_acc && !ack_prev_m;
    m_id = w1_id;
    m_lvl = w1_lvl;
    src_prev_m = src;
    ack_prev_m = ack_acc;
    w1_v = nv; w1_id = nid; w1_lvl = nlv;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (!rst_ni) model_reset();
    check("model_valid", {63'd0, valid}, {63'd0, m_valid});
    if (m_valid) begin
      check("model_id", {56'd0, id}, 64'(m_id));
      check("model_level", {56'd0, lvl_o}, 64'(m_lvl));
    end
    check_vec("model_pending", pending, model_pending());
    if (rst_ni) model_step();
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_level(input int k, input logic [LevelWidth-1:0] v);
    level_vec[k*LevelWidth +: LevelWidth] = v;
  endtask

  int act_ids [12] = '{0, 1, 15, 16, 17, 37, 55, 100, 128, 200, 254, 255};

  initial begin
    tick(3);
    check("reset_valid", {63'd0, valid}, 64'd0);
    check("reset_id", {56'd0, id}, 64'd0);
    rst_ni = 1'b1;

    // Single level source
    set_level(37, 8'd5); src[37] = 1'b1;
    tick(1); check("lvl_t1_valid", {63'd0, valid}, 64'd0);
    tick(1); check("lvl_t2_valid", {63'd0, valid}, 64'd1);
    check("lvl_t2_id", {56'd0, id}, 64'd37);
    check("lvl_t2_level", {56'd0, lvl_o}, 64'd5);
    tick(8); src[37] = 1'b0;
    tick(1); check("lvl_off_t11", {63'd0, valid}, 64'd1);
    tick(1); check("lvl_off_t12", {63'd0, valid}, 64'd0);

    // Tie and priority
    set_level(3, 8'd7); set_level(200, 8'd7); set_level(100, 8'd6);
    src[3] = 1'b1; src[200] = 1'b1; src[100] = 1'b1;
    tick(2); check("tie_id", {56'd0, id}, 64'd200);
    set_level(100, 8'd9);
    tick(1); check("tie_hold_valid", {63'd0, valid}, 64'd1);
    check("tie_hold_id", {56'd0, id}, 64'd200);
    tick(1); check("prio_valid", {63'd0, valid}, 64'd1);
    check("prio_id", {56'd0, id}, 64'd100);
    check("prio_level", {56'd0, lvl_o}, 64'd9);
    src[3] = 1'b0; src[200] = 1'b0; src[100] = 1'b0;
    tick(3);

    // Threshold is strict
    set_level(10, 8'd4); thresh = 8'd4; src[10] = 1'b1;
    tick(3); check("thresh_eq", {63'd0, valid}, 64'd0);
    thresh = 8'd3;
    tick(1); check("thresh_below", {63'd0, valid}, 64'd1);
    check("thresh_id", {56'd0, id}, 64'd10);
    src[10] = 1'b0; thresh = 8'd0;
    tick(3);

    // Edge source and ack
    edge_mode[55] = 1'b1; set_level(55, 8'd3);
    src[55] = 1'b1;
    tick(1); src[55] = 1'b0;
    check("edge_ip", {63'd0, pending[55]}, 64'd1);
    tick(1); check("edge_t2", {63'd0, valid}, 64'd0);
    tick(1); check("edge_t3", {63'd0, valid}, 64'd1);
    check("edge_id", {56'd0, id}, 64'd55);
    tick(2); ack = 1'b1;
    tick(1); ack = 1'b0;
    check("ack_t6_valid", {63'd0, valid}, 64'd0);
    check("ack_t6_pend", {63'd0, pending[55]}, 64'd0);
    tick(1); check("ack_t7_valid", {63'd0, valid}, 64'd0);
    tick(1); check("ack_t8_valid", {63'd0, valid}, 64'd0);

    // Re-pulse coincident with the ack: set wins
    src[55] = 1'b1;
    tick(1); src[55] = 1'b0;
    tick(2); check("edge2_t3", {63'd0, valid}, 64'd1);
    tick(2); ack = 1'b1; src[55] = 1'b1;
    tick(1); ack = 1'b0; src[55] = 1'b0;
    check("setwin_pend", {63'd0, pending[55]}, 64'd1);
    check("setwin_t6", {63'd0, valid}, 64'd0);
    tick(1); check("setwin_t7", {63'd0, valid}, 64'd0);
    tick(1); check("setwin_t8", {63'd0, valid}, 64'd1);
    check("setwin_id", {56'd0, id}, 64'd55);
    ack = 1'b1;
    tick(1); ack = 1'b0;
    tick(3);

    // Masked source and ignored ack
    ie[20] = 1'b0; set_level(20, 8'd9); src[20] = 1'b1;
    tick(4); check("mask_valid", {63'd0, valid}, 64'd0);
    check("mask_pend", {63'd0, pending[20]}, 64'd1);
    ie[20] = 1'b1; src[20] = 1'b0;
    tick(3);
    ack = 1'b1; src[37] = 1'b1;
    tick(1); ack = 1'b0;
    tick(1); check("ign_ack_valid", {63'd0, valid}, 64'd1);
    check("ign_ack_id", {56'd0, id}, 64'd37);
    src[37] = 1'b0;
    tick(3);

    // Async reset mid-operation
    src[55] = 1'b1;
    tick(1); src[55] = 1'b0;
    tick(2); check("rst_pre_valid", {63'd0, valid}, 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_async_valid", {63'd0, valid}, 64'd0);
    check("rst_async_id", {56'd0, id}, 64'd0);
    check("rst_async_level", {56'd0, lvl_o}, 64'd0);
    check("rst_async_pend", {63'd0, pending[55]}, 64'd0);
    @(posedge clk); #1 rst_ni = 1'b1;
    tick(5); check("rst_post_valid", {63'd0, valid}, 64'd0);

    // Randomized traffic on a sparse set of sources spanning group boundaries
    for (int i = 0; i < 3000; i++) begin
      ack = !ack && ($urandom_range(3) == 0);
      foreach (act_ids[j]) begin
        if ($urandom_range(3) == 0) src[act_ids[j]] = ~src[act_ids[j]];
        if ($urandom_range(63) == 0) edge_mode[act_ids[j]] = ~edge_mode[act_ids[j]];
        if ($urandom_range(31) == 0) ie[act_ids[j]] = ($urandom_range(7) != 0);
        if ($urandom_range(15) == 0) set_level(act_ids[j], 8'($urandom_range(7)));
      end
      if ($urandom_range(15) == 0) thresh = 8'($urandom_range(4));
      tick(1);
      if (i == 1500) begin
        #2 rst_ni = 1'b0;
        @(posedge clk); #1 rst_ni = 1'b1;
      end
    end
    ack = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cva6_clic_irq_arbiter.md
# cva6_clic_irq_arbiter

Parametrised CLIC interrupt arbiter for CVA6 cores built with `RVSCLIC` enabled. It latches edge-triggered sources and selects the highest-level enabled pending source above the current threshold, using a two-stage registered comparator tree. It presents the winner to the CSR/controller through a valid/ack handshake. It replaces the fixed 256-source selector and adds:
- source count and level width as parameters,
- per-source edge/level trigger mode,
- a pipelined tree,
- ack blanking.

## Interface
- `NumSrc`, 256: number of interrupt sources (`CLICNumInterruptSrc`), ≥2.
- `LevelWidth`, 8: width of per-source level/priority field.
- `GroupSize`, 16: sources per first-stage group; `NumSrc` must be a multiple of `GroupSize`.
- `IdWidth`, `$clog2(NumSrc)`: derived, do not override.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `src_i`, in, `NumSrc`: raw interrupt lines.
- `ie_i`, in, `NumSrc`: per-source enable (`clicintie`).
- `edge_i`, in, `NumSrc`: trigger mode, 1 = rising-edge, 0 = level.
- `level_i`, in, `NumSrc*LevelWidth`: per-source level; source k occupies bits `[k*LevelWidth +: LevelWidth]`.
- `thresh_i`, in, `LevelWidth`: effective threshold, the max of `mintstatus` level and `mintthresh`.
- `irq_valid_o`, out, 1: a qualifying interrupt is presented.
- `irq_id_o`, out, `IdWidth`: winning source id.
- `irq_level_o`, out, `LevelWidth`: winning level.
- `irq_ack_i`, in, 1: core takes the presented interrupt; 1-cycle pulse.
- `pending_o`, out, `NumSrc`: effective pending vector, for `clicintip` reads.

## Operation
- Pending, per source k:
  - Level mode: `pending[k] = src_i[k]`.
  - Edge mode: `ip_q[k]` is set on a rising edge of `src_i[k]` against the registered `src_q[k]`, and cleared by an accepted ack whose `irq_id_o == k`.
  - Set and clear in the same cycle: set wins.
  - Switching `edge_i[k]` from 1 to 0 clears `ip_q[k]` in the next cycle.
- Candidate: `cand[k] = pending[k] & ie_i[k]`.
- Stage 1:
  - Each group of `GroupSize` sources reduces combinationally to a `{valid, level, id}` winner.
  - Greater level wins; on equal level the higher id wins. Non-candidates never win.
  - Result is registered into `grp_q`.
- Stage 2:
  - `NumSrc/GroupSize` group winners reduce with the same rule.
  - Qualification is `valid && level > thresh_i`, strict compare; `thresh_i` is sampled at stage 2.
  - Result is registered into the outputs.
- Ack:
  - Accepted only when `irq_ack_i && irq_valid_o`; an ack while valid is low is ignored with no state change.
  - An accepted ack clears the edge pending of `irq_id_o` (no effect for a level source).
  - It also starts a 2-cycle blanking counter. During blanking, `irq_valid_o` is forced 0 so pipeline contents computed before the clear are never presented.
- Preemption: with no ack, outputs follow the tree every cycle. A higher-level arrival replaces `irq_id_o`/`irq_level_o` while `irq_valid_o` stays 1.
- Reset, asynchronous:
  - `src_q`, `ip_q`, `grp_q` and the blanking counter go to 0.
  - `irq_valid_o=0`, `irq_id_o=0`, `irq_level_o=0`.
  - `pending_o` reflects only level sources (edge `ip_q` = 0).
  - Reset mid-operation discards all in-flight winners.

## Timing
- `pending_o`:
  - Level sources: combinational from `src_i`.
  - Edge sources: registered (edge at cycle t → visible at t+1).
- Source-to-output latency:
  - Level source asserted at t → `irq_valid_o` at t+2.
  - Edge source rising at t → `ip_q` at t+1 → `irq_valid_o` at t+3.
- Threshold change at t → reflected at t+1 (stage 2 input only).
- Ack at t:
  - `irq_valid_o` = 0 at t+1 and t+2.
  - From t+3 it shows the tree result computed from post-clear pending.
- Back-to-back acks are impossible by construction: valid is low during blanking.

## Test plan
- Single level source: `NumSrc=256`, src 37 level 5, ie=1, `thresh=0`, assert at t → `valid=1`, `id=37`, `level=5` at t+2. Deassert at t+10 → `valid=0` at t+12.
- Tie and priority: src 3 level 7, src 200 level 7, src 100 level 6 → `id=200`. Raise src 100 to level 9 → `id=100` two cycles later, valid held high throughout.
- Threshold: src 10 level 4, `thresh=4` → `valid=0`. `thresh=3` → `valid=1` next cycle.
- Edge and ack:
  - Edge src 55, 1-cycle pulse at t → `valid` at t+3, `id=55`.
  - Ack at t+5 → `valid=0` at t+6 and t+7; `pending_o[55]=0` at t+6; `valid` stays 0 at t+8.
  - Second pulse coincident with the ack → pending stays 1, re-presented at t+8.
- Masking and ignored ack: src 20 pending with `ie=0` → never valid. `irq_ack_i` pulsed while valid low → no state change, no blanking.
- Async reset mid-operation: with `valid=1` and edge pending set, drop `rst_ni` between clock edges → all outputs 0 immediately. After release with sources idle, `valid` stays 0.
